bounce_motion_ctrl: RTL and testbench

//  Parametrised per-frame motion engine for a bouncing VGA sprite (text/logo box). Runs in the

---
 rtl/bounce_motion_ctrl_if.sv | 29 ++
 rtl/bounce_motion_ctrl.sv | 120 ++++++++++++
 tb/tb_bounce_motion_ctrl.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bounce_motion_ctrl_if.sv
// Control/status bundle between the frame-timing source, the motion engine and the renderer.
// The master drives the per-frame controls, and the slave (the motion engine) returns position and events.
interface bounce_motion_ctrl_if #(
  parameter int STEP_W     = 4,
  parameter int COLOR_BITS = 2
);
  logic                  frame_tick;
  logic                  enable;
  logic [STEP_W-1:0]     step_x;
  logic [STEP_W-1:0]     step_y;
  logic [9:0]            obj_x;
  logic [9:0]            obj_y;
  logic                  dir_right;
  logic                  dir_down;
  logic                  bounce_x;
  logic                  bounce_y;
  logic                  corner_hit;
  logic [COLOR_BITS-1:0] color_idx;

  modport master (
    output frame_tick, enable, step_x, step_y,
    input  obj_x, obj_y, dir_right, dir_down, bounce_x, bounce_y, corner_hit, color_idx
  );

  modport slave (
    input  frame_tick, enable, step_x, step_y,
    output obj_x, obj_y, dir_right, dir_down, bounce_x, bounce_y, corner_hit, color_idx
  );
endinterface

// File: rtl/bounce_motion_ctrl.sv
// Per-frame motion engine for a bouncing sprite: divides frame ticks, steps the position,
// reflects and clamps it at a padded border, and emits bounce/corner pulses plus a colour index.
module bounce_motion_ctrl #(
  parameter int H_VISIBLE  = 640,
  parameter int V_VISIBLE  = 480,
  parameter int OBJ_W      = 85,
  parameter int OBJ_H      = 50,
  parameter int PAD        = 50,
  parameter int X_INIT     = 50,
  parameter int Y_INIT     = 50,
  parameter int STEP_W     = 4,
  parameter int FRAME_DIV  = 2,
  parameter int COLOR_BITS = 2
) (
  input logic                 clk,
  input logic                 rst_n,
  bounce_motion_ctrl_if.slave bus
);

  localparam logic [10:0] XMIN = 11'(PAD);
  localparam logic [10:0] YMIN = 11'(PAD);
  localparam logic [10:0] XMAX = 11'(H_VISIBLE - PAD - OBJ_W);
  localparam logic [10:0] YMAX = 11'(V_VISIBLE - PAD - OBJ_H);
  localparam int          DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       bounce;
  } axis_t;

  logic [9:0]            x_q, y_q;
  logic                  dir_right_q, dir_down_q;
  logic                  bounce_x_q, bounce_y_q, corner_q;
  logic [COLOR_BITS-1:0] color_q;
  logic [DIV_W-1:0]      div_q;
  axis_t                 nx, ny;
  logic                  update;

  // 11-bit arithmetic so pos+step cannot wrap; a zero step leaves the axis untouched.
  function automatic axis_t axis_step(input logic [9:0] pos, input logic fwd,
                                      input logic [10:0] step, input logic [10:0] lo,
                                      input logic [10:0] hi);
    axis_t       r;
    logic [10:0] sum;
    r.pos    = pos;
    r.dir    = fwd;
    r.bounce = 1'b0;
    sum      = {1'b0, pos} + step;
    if (step != '0) begin
      if (fwd) begin
        if (sum >= hi) begin
          r.pos    = 10'(hi);
          r.dir    = 1'b0;
          r.bounce = 1'b1;
        end else begin
          r.pos = 10'(sum);
        end
      end else begin
        if ({1'b0, pos} <= lo + step) begin
          r.pos    = 10'(lo);
          r.dir    = 1'b1;
          r.bounce = 1'b1;
        end else begin
          r.pos = pos - 10'(step);
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    nx     = axis_step(x_q, dir_right_q, 11'(bus.step_x), XMIN, XMAX);
    ny     = axis_step(y_q, dir_down_q,  11'(bus.step_y), YMIN, YMAX);
    update = bus.frame_tick && bus.enable && (div_q == DIV_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q         <= 10'(X_INIT);
      y_q         <= 10'(Y_INIT);
      dir_right_q <= 1'b1;
      dir_down_q  <= 1'b1;
      bounce_x_q  <= 1'b0;
      bounce_y_q  <= 1'b0;
      corner_q    <= 1'b0;
      color_q     <= '0;
      div_q       <= '0;
    end else begin
      bounce_x_q <= 1'b0;
      bounce_y_q <= 1'b0;
      corner_q   <= 1'b0;
      if (bus.frame_tick && bus.enable) begin
        if (update) div_q <= '0;
        else        div_q <= DIV_W'(div_q + 1'b1);
      end
      if (update) begin
        x_q         <= nx.pos;
        y_q         <= ny.pos;
        dir_right_q <= nx.dir;
        dir_down_q  <= ny.dir;
        bounce_x_q  <= nx.bounce;
        bounce_y_q  <= ny.bounce;
        corner_q    <= nx.bounce & ny.bounce;
        color_q     <= color_q + COLOR_BITS'(nx.bounce | ny.bounce);
      end
    end
  end

  assign bus.obj_x      = x_q;
  assign bus.obj_y      = y_q;
  assign bus.dir_right  = dir_right_q;
  assign bus.dir_down   = dir_down_q;
  assign bus.bounce_x   = bounce_x_q;
  assign bus.bounce_y   = bounce_y_q;
  assign bus.corner_hit = corner_q;
  assign bus.color_idx  = color_q;

endmodule

// File: tb/tb_bounce_motion_ctrl.sv
// Directed bench for bounce_motion_ctrl: one instance moving every frame, one dividing by two.
module tb_bounce_motion_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  bounce_motion_ctrl_if #(.STEP_W(4), .COLOR_BITS(2)) a ();
  bounce_motion_ctrl_if #(.STEP_W(4), .COLOR_BITS(2)) b ();

  bounce_motion_ctrl #(.FRAME_DIV(1)) dut_a (.clk(clk), .rst_n(rst_n), .bus(a.slave));
  bounce_motion_ctrl #(.FRAME_DIV(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One frame tick on instance a (sel=0) or b (sel=1); outputs are sampled 1 ns after the edge.
  task automatic tick(input bit sel, input logic [3:0] sx, input logic [3:0] sy, input logic en);
    @(negedge clk);
    if (!sel) begin a.step_x = sx; a.step_y = sy; a.enable = en; a.frame_tick = 1'b1; end
    else      begin b.step_x = sx; b.step_y = sy; b.enable = en; b.frame_tick = 1'b1; end
    @(posedge clk);
    #1;
    a.frame_tick = 1'b0;
    b.frame_tick = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_a(input string tag, input int x, input int y, input bit dr, input bit dd,
                         input bit bx, input bit by, input bit cr, input int col);
    check_val({tag, ".obj_x"},      32'(a.obj_x),      32'(x));
    check_val({tag, ".obj_y"},      32'(a.obj_y),      32'(y));
    check_val({tag, ".dir_right"},  32'(a.dir_right),  32'(dr));
    check_val({tag, ".dir_down"},   32'(a.dir_down),   32'(dd));
    check_val({tag, ".bounce_x"},   32'(a.bounce_x),   32'(bx));
    check_val({tag, ".bounce_y"},   32'(a.bounce_y),   32'(by));
    check_val({tag, ".corner_hit"}, 32'(a.corner_hit), 32'(cr));
    check_val({tag, ".color_idx"},  32'(a.color_idx),  32'(col));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    a.frame_tick = 1'b0; a.enable = 1'b1; a.step_x = '0; a.step_y = '0;
    b.frame_tick = 1'b0; b.enable = 1'b1; b.step_x = '0; b.step_y = '0;
    repeat (2) @(posedge clk);
    #1;
    check_a("reset", 50, 50, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single plain step, no bounce.
    tick(0, 4'd4, 4'd0, 1'b1);
    check_a("step4", 54, 50, 1, 0 + 1, 0, 0, 0, 0);

    // Walk x to 503 and bounce on the right edge.
    do_reset();
    for (int unsigned i = 0; i < 30; i++) tick(0, 4'd15, 4'd0, 1'b1);
    tick(0, 4'd3, 4'd0, 1'b1);
    check_a("pre_right", 503, 50, 1, 1, 0, 0, 0, 0);
    tick(0, 4'd4, 4'd0, 1'b1);
    check_a("right_bounce", 505, 50, 0, 1, 1, 0, 0, 1);
    @(posedge clk);
    #1;
    check_val("right_bounce.pulse_drop", 32'(a.bounce_x), 32'd0);

    // Walk to (503,378) and hit the bottom-right corner.
    do_reset();
    for (int unsigned i = 0; i < 30; i++)
      tick(0, 4'd15, (i < 21) ? 4'd15 : ((i == 21) ? 4'd13 : 4'd0), 1'b1);
    tick(0, 4'd3, 4'd0, 1'b1);
    check_a("pre_corner", 503, 378, 1, 1, 0, 0, 0, 0);
    tick(0, 4'd4, 4'd4, 1'b1);
    check_a("corner", 505, 380, 0, 0, 1, 1, 1, 1);
    @(posedge clk);
    #1;
    check_val("corner.pulse_drop", 32'(a.corner_hit), 32'd0);

    // Travel back left to 52, then bounce on the left edge.
    for (int unsigned i = 0; i < 30; i++) tick(0, 4'd15, 4'd0, 1'b1);
    check_val("left_walk.obj_x", 32'(a.obj_x), 32'd55);
    tick(0, 4'd3, 4'd0, 1'b1);
    check_val("pre_left.obj_x", 32'(a.obj_x), 32'd52);
    tick(0, 4'd4, 4'd0, 1'b1);
    check_a("left_bounce", 50, 380, 1, 0, 1, 0, 0, 2);

    // Frozen: a tick with enable low changes nothing.
    tick(0, 4'd4, 4'd4, 1'b0);
    check_a("frozen", 50, 380, 1, 0, 0, 0, 0, 2);

    // Asynchronous reset mid-cycle takes effect without a clock edge.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_a("async_reset", 50, 50, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Divide-by-two: the disabled tick in the middle must not advance the divider.
    tick(1, 4'd1, 4'd0, 1'b1);
    check_val("div.T1.obj_x", 32'(b.obj_x), 32'd50);
    tick(1, 4'd1, 4'd0, 1'b0);
    check_val("div.T2.obj_x", 32'(b.obj_x), 32'd50);
    tick(1, 4'd1, 4'd0, 1'b1);
    check_val("div.T3.obj_x", 32'(b.obj_x), 32'd51);
    check_val("div.T3.obj_y", 32'(b.obj_y), 32'd50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
